seg7_bcd_scan: RTL
==================

# seg7_bcd_scan

Four-digit seven-segment display driver that consumes the 12-bit bell-frequency divisor (`Nfreq`, range 1000–1750, full input range 0–4095) produced alongside the PWM bell stage. It converts the value to BCD with a sequential shift-add-3 (double-dabble) engine and time-multiplexes the four digits onto the board's common-anode display. It sits at top level, downstream of the `Nfreq` register, and drives `sseg` and `an` directly.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot (1 ms at 50 MHz); legal range is ≥2.
- `BLANK_LZ`, 1: when 1, leading zeros are blanked; when 0, all four digits are always lit.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `numA` in 12: unsigned binary value to display; sampled only in IDLE.
- `sseg` out [0:6]: segments a..g, active-low, registered.
- `an` out 4: digit anodes, active-low one-hot, registered; `an[0]` is the units (rightmost) digit.
- `busy` out 1: high while a conversion is in progress (CONV or LOAD).

## Operation
- Registers: `last[11:0]`, `shreg` (12-bit binary and 16-bit BCD), `cnt[3:0]`, `dig3..dig0[3:0]` (display copy), prescaler, `idx[1:0]`.
- FSM states:
  - IDLE: when `numA != last`, latch `numA` into `last` and into the binary part of `shreg`, clear the BCD part, set `cnt=0`, and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble that is ≥5, then shift the combined register left by 1 with the binary MSB entering the BCD LSB, and increment `cnt`. After the 12th iteration (`cnt==11`), go to LOAD.
  - LOAD: copy the BCD nibbles into `dig3..dig0` in one atomic load, then go to IDLE.
- `numA` changes during CONV or LOAD are ignored. They are caught on the first IDLE cycle, because `last` holds the value that is being converted.
- The display copy only ever holds completed conversions; it never shows intermediate shift values.
- Scanning: the prescaler counts 0..`REFRESH_DIV-1`. When it wraps, `idx` advances 0→1→2→3→0.
- Each cycle:
  - `an` is registered as the active-low one-hot of `idx`: idx0 gives 1110, idx3 gives 0111.
  - `sseg` is registered as the decode of `dig[idx]`, or 1111111 when that digit is blanked.
- Decode (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Nibble values above 9 cannot occur; if they do, the digit decodes as blank.
- Blanking, with `BLANK_LZ=1`: digit i (for i≥1) is blank when `dig[i]` and every higher digit are all 0. The units digit is never blanked.

## Timing
- Reset values:
  - FSM in IDLE, `last=0`, `dig*=0`, prescaler 0, `idx=0`, `cnt=0`.
  - `busy=0`, `an=1110`, `sseg=0000001` (shows "0").
- Reset is synchronous and overrides everything, including mid-conversion. Any conversion in progress is discarded and `dig*` is cleared to 0.
- Conversion latency:
  - `numA` differs from `last` at rising edge k, with the FSM in IDLE.
  - Edges k+1..k+12 perform the 12 iterations.
  - Edge k+13 executes LOAD; `dig*` is valid after it.
  - `busy` is 1 after edges k through k+12 and 0 after edge k+13.
- Worst case after a mid-conversion change: the new value is displayed no later than 27 cycles after it appears.
- `an` and `sseg` change together, exactly one cycle after `idx` changes. This gives one digit change per `REFRESH_DIV` cycles and a full frame every 4·`REFRESH_DIV` cycles.
- `dig*` updating mid-slot takes effect on `sseg` one cycle after LOAD, without waiting for the next slot.

## Test plan
- **Reset.** Stimulus: `rst` high for 2 cycles with `numA=0`, `REFRESH_DIV=4`. Required: `an=1110`, `sseg=0000001`, `busy=0`. Over the full frame, slots 1–3 show `sseg=1111111`.
- **Minimum divisor.** Stimulus: `numA=1000`. Required:
  - `busy` high for exactly 13 cycles; `dig3..0=1,0,0,0`.
  - Scan gives an=1110/0000001, 1101/0000001, 1011/0000001, 0111/1001111.
- **Maximum divisor and full range.** Stimulus: `numA=1750`, then `numA=4095`. Required: digits 1,7,5,0, then 4,0,9,5. Slot 3 shows `sseg=1001100` for the 4.
- **Leading-zero blanking.** Stimulus: `numA=7` with `BLANK_LZ=1`. Required: slot 0 shows `sseg=0001111`; slots 1–3 show 1111111. Same stimulus with `BLANK_LZ=0`: slots 1–3 show 0000001.
- **Mid-conversion change.** Stimulus: `numA=1000`, switched to 1050 on the 5th CONV cycle. Required:
  - Display goes to 1000 after LOAD, then `busy` re-asserts on the next cycle.
  - Display goes to 1050 at most 14 cycles later.
  - `dig*` never holds any other value.
- **Reset mid-conversion.** Stimulus: `rst` asserted on the 6th CONV cycle while `numA=1750`. Required: after that edge, `busy=0` and `dig*=0`. After release, `busy` rises on the next edge and digits reach 1,7,5,0 after 13 more cycles.

Source files
------------

// File: rtl/seg7_bcd_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_bcd_scan : 12-bit binary -> 4-digit BCD (double-dabble), muxed 7-seg
// Revision 1.0
// ---------------------------------------------------------------------------
module seg7_bcd_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] numA,
  output logic [0:6]  sseg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int            PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [0:6]    SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t        state;
  logic [11:0]   last;
  logic [27:0]   shreg;
  logic [3:0]    cnt;
  logic [3:0]    dig0, dig1, dig2, dig3;
  logic [15:0]   bcd_adj;

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    cur_dig;
  logic          cur_blank;
  logic [0:6]    seg_dec;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = shreg[27:12];
    for (int i = 0; i < 4; i++) begin
      if (shreg[12 + 4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = shreg[12 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= '0;
      shreg <= '0;
      cnt   <= '0;
      dig0  <= '0;
      dig1  <= '0;
      dig2  <= '0;
      dig3  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (numA != last) begin
            last  <= numA;
            shreg <= {16'd0, numA};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          shreg <= {bcd_adj, shreg[11:0]} << 1;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd11) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // All four digits update in the same edge so the display never tears.
          dig3  <= shreg[27:24];
          dig2  <= shreg[23:20];
          dig1  <= shreg[19:16];
          dig0  <= shreg[15:12];
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_comb begin
    case (idx)
      2'd0:    cur_dig = dig0;
      2'd1:    cur_dig = dig1;
      2'd2:    cur_dig = dig2;
      default: cur_dig = dig3;
    endcase
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    cur_blank = 1'b0;
    if (BLANK_LZ) begin
      case (idx)
        2'd1:    cur_blank = (dig1 == 4'd0) && (dig2 == 4'd0) && (dig3 == 4'd0);
        2'd2:    cur_blank = (dig2 == 4'd0) && (dig3 == 4'd0);
        2'd3:    cur_blank = (dig3 == 4'd0);
        default: cur_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (cur_dig)
      4'd0:    seg_dec = 7'b0000001;
      4'd1:    seg_dec = 7'b1001111;
      4'd2:    seg_dec = 7'b0010010;
      4'd3:    seg_dec = 7'b0000110;
      4'd4:    seg_dec = 7'b1001100;
      4'd5:    seg_dec = 7'b0100100;
      4'd6:    seg_dec = 7'b0100000;
      4'd7:    seg_dec = 7'b0001111;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0000100;
      default: seg_dec = SEG_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= 4'b1110;
      sseg <= 7'b0000001;
    end else begin
      an   <= ~(4'b0001 << idx);
      sseg <= cur_blank ? SEG_OFF : seg_dec;
    end
  end

endmodule
`default_nettype wire
